// File: rtl/parity_frame_controller.sv
// -----------------------------------------------------------------------------
// parity_frame_controller
//
// Sequencing controller for the even-parity datapath. A frame (data word plus
// its transmitted parity bit) is accepted over a valid/ready handshake. The
// word is then shifted LSB-first through a one-bit even-parity tracker at one
// bit per clock. The tracker result is compared with the received parity bit,
// and the verdict is offered on an output valid/ready handshake.
//
// Timing for an accept on edge T:
//   - SHIFT occupies edges T+1 .. T+WIDTH.
//   - CHECK registers the verdict on edge T+WIDTH+1.
//   - The next accept can happen at the earliest one cycle after the output
//     handshake, so the minimum frame period is WIDTH+3 cycles.
//
// Optional feature macro: PARITY_ERR_COUNT_EN
//   When defined, a saturating err_count output counts handshaken verdicts
//   that carry out_err=1.
//
// Parameters
//   WIDTH     data bits per frame, 1..32
//   ERRCNT_W  width of err_count (only meaningful with PARITY_ERR_COUNT_EN)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   producer presents a frame
//   in_ready   frame can be accepted (IDLE and reset low)
//   in_data    frame data, bit 0 shifted first
//   in_par     received even-parity bit for in_data
//   busy       controller is not IDLE
//   out_valid  verdict available
//   out_ready  consumer takes the verdict
//   out_err    1 = received parity disagrees with computed parity
//   out_parity computed even-parity bit of the frame data
//   err_count  saturating error count (PARITY_ERR_COUNT_EN only)
// -----------------------------------------------------------------------------
module parity_frame_controller #(
    parameter int WIDTH    = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err,
    output logic             out_parity
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    // Counter spans 0..WIDTH so it can never wrap, even for WIDTH=1.
    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT_C = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_width_check
        $error("parity_frame_controller: WIDTH must be in 1..32");
    end
    if (ERRCNT_W < 1) begin : g_errcnt_check
        $error("parity_frame_controller: ERRCNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] sreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             tracker_r;
    logic             par_rx_r;
    logic             out_valid_r;
    logic             out_err_r;
    logic             out_parity_r;
    logic             accept_s;
    logic             release_s;

    // One step of the serial even-parity accumulation.
    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // A frame is in error when computed and received parity disagree.
    function automatic logic parity_mismatch(input logic computed, input logic received);
        return computed ^ received;
    endfunction

    assign accept_s  = in_valid & in_ready;
    assign release_s = out_valid_r & out_ready;

    assign out_valid  = out_valid_r;
    assign out_err    = out_err_r;
    assign out_parity = out_parity_r;

    // State register with synchronous reset that overrides any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_BIT_C) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (release_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State-derived status outputs; in_ready is also masked by reset so that
    // no handshake is advertised while reset is held.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                in_ready = ~reset;
                busy     = 1'b0;
            end
            ST_SHIFT, ST_CHECK, ST_DONE: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

    // Frame datapath: capture, serial parity tracking and verdict registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_r       <= '0;
            cnt_r        <= '0;
            tracker_r    <= 1'b0;
            par_rx_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_err_r    <= 1'b0;
            out_parity_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sreg_r    <= in_data;
                        par_rx_r  <= in_par;
                        tracker_r <= 1'b0;
                        cnt_r     <= '0;
                    end
                end
                ST_SHIFT: begin
                    tracker_r <= parity_step(tracker_r, sreg_r[0]);
                    sreg_r    <= sreg_r >> 1;
                    cnt_r     <= cnt_r + CNT_ONE_C;
                end
                ST_CHECK: begin
                    out_parity_r <= tracker_r;
                    out_err_r    <= parity_mismatch(tracker_r, par_rx_r);
                    out_valid_r  <= 1'b1;
                end
                ST_DONE: begin
                    // Verdict bits stay as they are after the handshake.
                    if (release_s) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    localparam logic [ERRCNT_W-1:0] ERR_MAX_C = '1;
    localparam logic [ERRCNT_W-1:0] ERR_ONE_C = ERRCNT_W'(1);

    logic [ERRCNT_W-1:0] err_count_r;

    assign err_count = err_count_r;

    // Saturating count of verdicts delivered with an error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_r <= '0;
        end else if (release_s && out_err_r && (err_count_r != ERR_MAX_C)) begin
            err_count_r <= err_count_r + ERR_ONE_C;
        end
    end
`endif

endmodule

// File: tb/tb_parity_frame_controller.sv
`timescale 1ns/1ps
module tb_parity_frame_controller;

    localparam int WIDTH    = 8;
    localparam int ERRCNT_W = 2;
    localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_par;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic             out_err;
    logic             out_parity;
`ifdef PARITY_ERR_COUNT_EN
    logic [ERRCNT_W-1:0] err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    // Transaction-level reference: a frame is either absent, aging toward its
    // verdict, or waiting for the consumer.
    bit             m_active = 1'b0;
    bit             m_valid  = 1'b0;
    bit             m_err    = 1'b0;
    bit             m_par    = 1'b0;
    int             m_age    = 0;
    logic [WIDTH-1:0] m_data = '0;
    logic           m_rxpar  = 1'b0;
    int             m_errcnt = 0;
    int             m_acc_cyc = 0;
    bit             m_acc_now = 1'b0;

    always #5 clk = ~clk;

    parity_frame_controller #(
        .WIDTH    (WIDTH),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_par     (in_par),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_err    (out_err),
        .out_parity (out_parity)
`ifdef PARITY_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model update on each active edge.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        m_acc_now <= 1'b0;
        if (reset) begin
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_err    <= 1'b0;
            m_par    <= 1'b0;
            m_age    <= 0;
            m_errcnt <= 0;
        end else if (m_active) begin
            if (m_valid) begin
                if (out_ready) begin
                    m_valid  <= 1'b0;
                    m_active <= 1'b0;
                    if (m_err && (m_errcnt < ERR_MAX)) m_errcnt <= m_errcnt + 1;
                end
            end else begin
                m_age <= m_age + 1;
                if (m_age + 1 == WIDTH + 1) begin
                    m_valid <= 1'b1;
                    m_par   <= (($countones(m_data) % 2) == 1);
                    m_err   <= ((($countones(m_data) + int'(m_rxpar)) % 2) == 1);
                end
            end
        end else if (in_valid) begin
            m_active  <= 1'b1;
            m_age     <= 0;
            m_data    <= in_data;
            m_rxpar   <= in_par;
            m_acc_cyc <= cyc + 1;
            m_acc_now <= 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("in_ready",   32'(in_ready),   32'(!m_active && (reset !== 1'b1)));
            check("busy",       32'(busy),       32'(m_active));
            check("out_valid",  32'(out_valid),  32'(m_valid));
            check("out_err",    32'(out_err),    32'(m_err));
            check("out_parity", 32'(out_parity), 32'(m_par));
`ifdef PARITY_ERR_COUNT_EN
            check("err_count",  32'(err_count),  32'(m_errcnt));
`endif
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic p, input bit keep_valid);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_acc_now) break;
        end
        check("accept_busy", 32'(busy), 32'd1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int k;
        k = 0;
        while ((out_valid !== 1'b1) && (k < 40)) begin
            tick();
            k++;
        end
        check("valid_seen", 32'(out_valid), 32'd1);
        lat = cyc - m_acc_cyc;
    endtask

    initial begin
        int lat;
        int acc_q[$];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_par    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_on = 1'b1;
        check("rst_in_ready",  32'(in_ready),   32'd0);
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_err",   32'(out_err),    32'd0);
        check("rst_out_par",   32'(out_parity), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Basic frame and latency.
        out_ready = 1'b1;
        send(8'hA5, 1'b0, 1'b0);
        wait_valid(lat);
        check("a5_latency", 32'(lat),        32'd9);
        check("a5_err",     32'(out_err),    32'd0);
        check("a5_parity",  32'(out_parity), 32'd0);
        tick();

        // Odd-weight word with wrong and right received parity.
        send(8'h07, 1'b0, 1'b0);
        wait_valid(lat);
        check("07p0_err",    32'(out_err),    32'd1);
        check("07p0_parity", 32'(out_parity), 32'd1);
        tick();
        send(8'h07, 1'b1, 1'b0);
        wait_valid(lat);
        check("07p1_err",    32'(out_err),    32'd0);
        check("07p1_parity", 32'(out_parity), 32'd1);
        tick();

        // Consumer stalls while the producer keeps offering.
        out_ready = 1'b0;
        send(8'h3C, 1'b1, 1'b0);
        wait_valid(lat);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_par   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_in_ready",  32'(in_ready),   32'd0);
            check("stall_out_valid", 32'(out_valid),  32'd1);
            check("stall_out_err",   32'(out_err),    32'd1);
            check("stall_out_par",   32'(out_parity), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        check("post_stall_accept", 32'(busy), 32'd1);
        wait_valid(lat);
        tick();

        // Reset in the fourth SHIFT cycle discards the frame.
        send(8'h5A, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_busy",     32'(busy),      32'd0);
        check("midrst_valid",    32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready),  32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("midrst_no_verdict", 32'(out_valid), 32'd0);
        send(8'hFF, 1'b0, 1'b0);
        wait_valid(lat);
        check("ff_err",    32'(out_err),    32'd0);
        check("ff_parity", 32'(out_parity), 32'd0);
        tick();

        // Back-to-back frames: accept edges spaced WIDTH+3 cycles apart.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; (i < 100) && (acc_q.size() < 6); i++) begin
            in_data = WIDTH'($urandom);
            in_par  = 1'($urandom);
            if (in_ready === 1'b1) acc_q.push_back(cyc + 1);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_count", 32'(acc_q.size()), 32'd6);
        for (int i = 1; i < acc_q.size(); i++) begin
            check("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd11);
        end

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            in_par    = 1'($urandom);
            tick();
        end
        reset    = 1'b0;
        in_valid = 1'b0;

`ifdef PARITY_ERR_COUNT_EN
        begin
            int exp_cnt[5] = '{1, 2, 3, 3, 3};
            reset = 1'b1;
            tick();
            reset     = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                send(8'h01, 1'b0, 1'b0);
                wait_valid(lat);
                tick();
                check("errcnt_sat", 32'(err_count), 32'(exp_cnt[i]));
            end
            send(8'h03, 1'b0, 1'b0);
            wait_valid(lat);
            tick();
            check("errcnt_good", 32'(err_count), 32'd3);
        end
`endif

        tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
